// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS CPU write-back / register-file slice.
//
// Contents:
//   DATA_W, ADDR_W : architectural register width and register address width
//   REG_ZERO       : address of the hard-wired zero register
//   wb_entry_t     : one buffered write-back {addr, data}
//   cnt_width()    : width of an occupancy count that can hold 0..depth
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One bit wider than the pointer so that "full" and "empty" differ.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry commit buffer for pending register write-backs.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the buffer)
//   push        : enqueue push_entry at the clock edge (caller guarantees room)
//   push_entry  : entry to enqueue
//   pop         : dequeue the head entry at the clock edge (caller guarantees
//                 the buffer is not empty)
//   head_entry  : oldest entry (valid when count != 0)
//   count       : number of valid entries, 0..DEPTH
//   entries     : age-ordered view, entries[0] = oldest; entries[i] is valid
//                 only when i < count. Used by the read-port bypass search.
// ---------------------------------------------------------------------------
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head_entry,
  output logic [CNT_W-1:0]        count,
  output wb_entry_t [DEPTH-1:0]   entries
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count are
  // cleared, which is enough to discard every buffered entry.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[PTR_W'(head + PTR_W'(i))];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Register file and write-back stage for the MIPS CPU. ALU results are
// accepted into a small commit buffer (wb_fifo) and retired one per cycle
// into a 2**ADDR_W x DATA_W register array. Two combinational read ports
// return source operands; register 0 always reads as zero.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  defined   : read ports search the buffered writes
//                                  youngest-to-oldest and return a hit, so
//                                  reads see every accepted write.
//                      undefined : read ports see only the committed array.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   regcWr/Addr/Data    : write request from the execute unit
//   wr_ready            : buffer accepts a write at this edge
//   hold                : freeze commit (stall / debug)
//   regaAddr, regaData  : read port A (combinational)
//   regbAddr, regbData  : read port B (combinational)
//   pending             : number of buffered, uncommitted writes
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regcWr,
  input  logic [ADDR_W-1:0] regcAddr,
  input  logic [DATA_W-1:0] regcData,
  output logic              wr_ready,
  input  logic              hold,
  input  logic [ADDR_W-1:0] regaAddr,
  input  logic [ADDR_W-1:0] regbAddr,
  output logic [DATA_W-1:0] regaData,
  output logic [DATA_W-1:0] regbData,
  output logic [CNT_W-1:0]  pending
);

  import cpu_pkg::*;

  wb_entry_t              push_entry;
  wb_entry_t              head_entry;
  wb_entry_t [DEPTH-1:0]  entries;
  logic [CNT_W-1:0]       count;
  logic                   push;
  logic                   pop;

  logic [DATA_W-1:0]      regs [2**ADDR_W];

  // ---------------------------------------------------------------------
  // Accept / commit control
  // ---------------------------------------------------------------------
  // A full buffer still accepts when not held: the head commits at the
  // same edge and frees the slot.
  assign wr_ready   = (count != CNT_W'(DEPTH)) || !hold;
  // Writes to r0 are accepted (handshake completes) but never buffered.
  assign push       = regcWr && wr_ready && (regcAddr != REG_ZERO);
  assign pop        = (count != '0) && !hold;
  assign push_entry = '{addr: regcAddr, data: regcData};
  assign pending    = count;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .entries    (entries)
  );

  // ---------------------------------------------------------------------
  // Register array: architectural state, cleared on reset. Entry 0 exists
  // only for uniform indexing; it is never written (r0 is never enqueued).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (pop) begin
      regs[head_entry.addr] <= head_entry.data;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports. The incoming regcData is never forwarded; only entries
  // already in the buffer can be bypassed.
  // ---------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    // NOTE: give every combinational result a value on every path up front
    // so no latch is inferred.
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // Oldest to youngest, so the youngest matching entry wins.
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (entries[i].addr == addr)) val = entries[i].data;
    end
`endif
    if (addr == REG_ZERO) val = '0;
    return val;
  endfunction

  always_comb regaData = read_port(regaAddr);
  always_comb regbData = read_port(regbAddr);

`ifndef REGFILE_BYPASS_EN
  // Entry view is only consumed by the bypass search.
  logic unused_entries;
  assign unused_entries = ^entries;
`endif

endmodule
